echo_delay_param: RTL and testbench

Parametrised echo/reverb stage for the audio sample path, sitting between the ADC front end and the DAC driver in the `sysclk` domain. It converts offset-binary ADC samples to signed values and adds an attenuated copy delayed by a run-time-programmable number of samples. The delay line is a circular buffer rather than a fixed FIFO. The stage supports single-tap (FIR) and recursive (IIR) echo, saturating arithmetic, bypass and overrun detection.

---
 rtl/echo_delay_param.sv | 168 ++++++++++++++++
 tb/tb_echo_delay_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/echo_delay_param.sv
// echo_delay_param
//   Echo/reverb stage for the audio sample path. Converts offset-binary ADC
//   samples to signed values, adds an attenuated copy taken from a circular
//   delay buffer (FIR: buffer holds x, IIR: buffer holds y), saturates the
//   sum and re-offsets it for the DAC.
//
// Ports
//   sysclk      sole clock, rising edge
//   rst         synchronous, active-high reset
//   data_valid  sample strobe level; a rising edge starts a sample
//   data_in     ADC sample, offset binary
//   delay_len   echo delay in samples, 0 disables the echo
//   gain_shift  arithmetic right shift (0..3) applied to the delayed term
//   mode        0 = FIR, 1 = IIR
//   bypass      forces the delayed term to zero; buffer still written
//   data_out    processed sample, offset binary
//   out_valid   one-cycle pulse when data_out updates
//   sat         clamp indicator, valid with out_valid
//   overrun     sticky: a strobe arrived while a sample was in flight
//
// Pipeline: S latch/read, S+1 echo term, S+2 sum + buffer write, S+3 output.
module echo_delay_param #(
  parameter int              WIDTH      = 10,
  parameter int              DEPTH      = 16,
  parameter logic [WIDTH-1:0] ADC_OFFSET = 'h181,
  parameter logic [WIDTH-1:0] DAC_OFFSET = 'h200,
  localparam int             AW         = $clog2(DEPTH)
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    delay_len,
  input  logic [1:0]       gain_shift,
  input  logic             mode,
  input  logic             bypass,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             sat,
  output logic             overrun
);

  logic             dv_prev_q, dv_prev_d;
  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [1:0]       gs_q, gs_d;
  logic             mode_q, mode_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW:0]      fill_q, fill_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_q, sat_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  logic                    strobe, busy, accept;
  logic [AW-1:0]           rd_addr;
  logic signed [WIDTH-1:0] d_term;
  logic [WIDTH:0]          sum;
  logic [WIDTH-1:0]        y;
  logic                    clamp;
  logic                    wr_en;
  logic [WIDTH-1:0]        wr_data;

  always_comb begin
    strobe  = data_valid & ~dv_prev_q;
    // Busy covers S+1..S+3; a strobe in those cycles is dropped.
    busy    = v1_q | v2_q | out_valid_q;
    accept  = strobe & ~busy;
    rd_addr = wp_q - delay_len;

    dv_prev_d   = data_valid;
    v1_d        = accept;
    v2_d        = v1_q;
    x_d         = x_q;
    gs_d        = gs_q;
    mode_d      = mode_q;
    zero_d      = zero_q;
    e_d         = e_q;
    wp_d        = wp_q;
    fill_d      = fill_q;
    data_out_d  = data_out_q;
    out_valid_d = v2_q;
    sat_d       = 1'b0;
    overrun_d   = overrun_q | (strobe & busy);
    wr_en       = 1'b0;
    wr_data     = x_q;

    if (accept) begin
      x_d    = data_in - ADC_OFFSET;
      gs_d   = gain_shift;
      mode_d = mode;
      // Warm-up gating keeps unwritten (or pre-reset) RAM contents out.
      zero_d = (delay_len == '0) | bypass | (fill_q < {1'b0, delay_len});
    end

    d_term = zero_q ? '0 : $signed(rdata_q);
    if (v1_q) e_d = d_term >>> gs_q;

    sum   = {x_q[WIDTH-1], x_q} + {e_q[WIDTH-1], e_q};
    clamp = sum[WIDTH] != sum[WIDTH-1];
    if (clamp)
      y = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      y = sum[WIDTH-1:0];

    if (v2_q) begin
      data_out_d = y + DAC_OFFSET;
      sat_d      = clamp;
      wr_en      = 1'b1;
      wr_data    = mode_q ? y : x_q;
      wp_d       = wp_q + AW'(1);
      if (fill_q != (AW+1)'(DEPTH)) fill_d = fill_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      dv_prev_q   <= 1'b1;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      x_q         <= '0;
      gs_q        <= '0;
      mode_q      <= 1'b0;
      zero_q      <= 1'b1;
      e_q         <= '0;
      wp_q        <= '0;
      fill_q      <= '0;
      data_out_q  <= DAC_OFFSET;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dv_prev_q   <= dv_prev_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      x_q         <= x_d;
      gs_q        <= gs_d;
      mode_q      <= mode_d;
      zero_q      <= zero_d;
      e_q         <= e_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  // Delay buffer: not reset; read and write never collide because the
  // read happens at S and the write at S+2 with 4-cycle strobe spacing.
  always_ff @(posedge sysclk) begin
    if (wr_en)  mem_q[wp_q] <= wr_data;
    if (accept) rdata_q     <= mem_q[rd_addr];
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign sat       = sat_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_delay_param.sv
module tb_echo_delay_param;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       data_valid = 1'b0;
  logic [9:0] data_in = 10'h181;
  logic [3:0] delay_len = 4'd0;
  logic [1:0] gain_shift = 2'd0;
  logic       mode = 1'b0;
  logic       bypass = 1'b0;
  logic [9:0] data_out;
  logic       out_valid;
  logic       sat;
  logic       overrun;

  int n_pass = 0;
  int n_total = 0;

  logic [9:0] fir_in  [5] = '{10'h1E5, 10'h181, 10'h181, 10'h181, 10'h181};
  logic [9:0] fir_exp [5] = '{10'h264, 10'h200, 10'h200, 10'h232, 10'h200};
  logic [9:0] iir_exp [9] = '{10'h264, 10'h200, 10'h232, 10'h200, 10'h219,
                              10'h200, 10'h20C, 10'h200, 10'h206};

  echo_delay_param dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .data_valid (data_valid),
    .data_in    (data_in),
    .delay_len  (delay_len),
    .gain_shift (gain_shift),
    .mode       (mode),
    .bypass     (bypass),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .sat        (sat),
    .overrun    (overrun)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset;
    @(negedge sysclk);
    rst = 1'b1;
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
  endtask

  // One sample every 8 cycles; output expected 3 cycles after the strobe.
  task automatic run_sample(input string tag, input logic [9:0] din,
                            input logic [9:0] exp_out, input logic exp_sat);
    int         lat = 0;
    int         pulses = 0;
    logic [9:0] dout = '0;
    logic       s = 1'b0;
    logic       stray = 1'b0;
    @(negedge sysclk);
    data_in    = din;
    data_valid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge sysclk);
      if (i == 2) data_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (lat == 0) begin
          lat  = i;
          dout = data_out;
          s    = sat;
        end
      end else if (sat) begin
        stray = 1'b1;
      end
    end
    check_val({tag, ".lat"}, lat, 3);
    check_val({tag, ".pulses"}, pulses, 1);
    check_val({tag, ".out"}, dout, exp_out);
    check_val({tag, ".sat"}, s, exp_sat);
    check_val({tag, ".sat_idle"}, stray, 0);
  endtask

  initial begin
    int         pulses;
    logic [9:0] dout;

    // Reset with data_valid held high: no strobe afterwards.
    data_valid = 1'b1;
    do_reset;
    @(negedge sysclk);
    check_val("rst.data_out", data_out, 10'h200);
    check_val("rst.out_valid", out_valid, 0);
    check_val("rst.overrun", overrun, 0);
    check_val("rst.sat", sat, 0);
    pulses = 0;
    repeat (8) begin
      @(negedge sysclk);
      if (out_valid) pulses++;
    end
    check_val("rst.no_pulse", pulses, 0);
    data_valid = 1'b0;

    // FIR impulse
    mode = 1'b0; delay_len = 4'd3; gain_shift = 2'd1;
    do_reset;
    for (int i = 0; i < 5; i++)
      run_sample($sformatf("fir%0d", i), fir_in[i], fir_exp[i], 1'b0);

    // IIR decay
    mode = 1'b1; delay_len = 4'd2; gain_shift = 2'd1;
    do_reset;
    for (int i = 0; i < 9; i++)
      run_sample($sformatf("iir%0d", i), (i == 0) ? 10'h1E5 : 10'h181, iir_exp[i], 1'b0);

    // Positive saturation
    mode = 1'b0; delay_len = 4'd1; gain_shift = 2'd0;
    do_reset;
    run_sample("psat0", 10'h311, 10'h390, 1'b0);
    run_sample("psat1", 10'h311, 10'h3FF, 1'b1);

    // Negative saturation, x = -300
    do_reset;
    run_sample("nsat0", 10'h055, 10'h0D4, 1'b0);
    run_sample("nsat1", 10'h055, 10'h000, 1'b1);

    // Overrun: second rising edge two cycles after the first
    mode = 1'b0; delay_len = 4'd3; gain_shift = 2'd1;
    do_reset;
    @(negedge sysclk); data_in = 10'h1E5; data_valid = 1'b1;
    @(negedge sysclk); data_valid = 1'b0;
    @(negedge sysclk); data_valid = 1'b1;
    pulses = 0; dout = '0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge sysclk);
      if (i == 2) data_valid = 1'b0;
      if (out_valid) begin pulses++; dout = data_out; end
    end
    check_val("ovr.pulses", pulses, 1);
    check_val("ovr.out", dout, 10'h264);
    check_val("ovr.flag", overrun, 1);
    run_sample("ovr_next", 10'h181, 10'h200, 1'b0);
    check_val("ovr.sticky", overrun, 1);
    do_reset;
    @(negedge sysclk);
    check_val("ovr.cleared", overrun, 0);

    // Bypass: echo suppressed, buffer still written
    bypass = 1'b1;
    run_sample("byp0", 10'h1E5, 10'h264, 1'b0);
    run_sample("byp1", 10'h181, 10'h200, 1'b0);
    run_sample("byp2", 10'h181, 10'h200, 1'b0);
    run_sample("byp3", 10'h181, 10'h200, 1'b0);
    bypass = 1'b0; delay_len = 4'd4;
    run_sample("byp_off", 10'h181, 10'h232, 1'b0);
    check_val("byp.overrun", overrun, 0);

    // Reset mid-sample, then warm-up after reset
    delay_len = 4'd3;
    do_reset;
    run_sample("pre0", 10'h1E5, 10'h264, 1'b0);
    run_sample("pre1", 10'h1E5, 10'h264, 1'b0);
    run_sample("pre2", 10'h1E5, 10'h264, 1'b0);
    run_sample("pre3", 10'h1E5, 10'h296, 1'b0);
    @(negedge sysclk); data_in = 10'h1E5; data_valid = 1'b1;
    @(negedge sysclk); rst = 1'b1; data_valid = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge sysclk);
      if (i == 2) rst = 1'b0;
      if (out_valid) pulses++;
    end
    check_val("mid.no_pulse", pulses, 0);
    check_val("mid.data_out", data_out, 10'h200);
    run_sample("warm0", 10'h1E5, 10'h264, 1'b0);
    run_sample("warm1", 10'h181, 10'h200, 1'b0);
    run_sample("warm2", 10'h181, 10'h200, 1'b0);
    run_sample("warm3", 10'h181, 10'h232, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
